// File: rtl/dummy_stim_gen.sv
// PRBS burst transmitter feeding the serial input of the dummy XOR chains; start/done handshake.
// First bit is on out two cycles after start is sampled; hold freezes the sequence in RUN with no bit lost.
module dummy_stim_gen #(
    parameter int                    LFSR_WIDTH  = 7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 7'h60,
    parameter logic [LFSR_WIDTH-1:0] SEED        = 7'h7F,
    parameter int                    BURST_LEN_W = 8,
    parameter int                    IDLE_GAP    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   reseed,
    input  logic [BURST_LEN_W-1:0] burst_len,
    input  logic                   hold,
    output logic                   out,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_LEN_W-1:0] bit_count
);

    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam logic [GAP_W-1:0]       GAP_INIT = GAP_W'(IDLE_GAP);
    localparam logic [GAP_W-1:0]       GAP_ONE  = GAP_W'(1);
    localparam logic [BURST_LEN_W-1:0] ONE_B    = BURST_LEN_W'(1);
    // An all-zero seed would lock the LFSR up forever.
    localparam logic [LFSR_WIDTH-1:0]  SEED_EFF = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [BURST_LEN_W-1:0]   remaining_q, remaining_d;
    logic [BURST_LEN_W-1:0]   bit_count_q, bit_count_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_EFF;
            remaining_q <= '0;
            bit_count_q <= '0;
            gap_q       <= '0;
            out_q       <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
            bit_count_q <= bit_count_d;
            gap_q       <= gap_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        bit_count_d = bit_count_q;
        gap_d       = gap_q;
        out_d       = 1'b0;
        valid_d     = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    bit_count_d = '0;
                    if (reseed) begin
                        lfsr_d = SEED_EFF;
                    end
                    if (burst_len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            S_RUN: begin
                if (hold) begin
                    out_d = out_q;
                end else begin
                    out_d       = lfsr_q[LFSR_WIDTH-1];
                    valid_d     = 1'b1;
                    lfsr_d      = {lfsr_q[LFSR_WIDTH-2:0], feedback};
                    remaining_d = remaining_q - ONE_B;
                    bit_count_d = bit_count_q + ONE_B;
                    if (remaining_q == ONE_B) begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            S_GAP: begin
                // done is raised on the final countdown step; the following edge returns to IDLE.
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d  = gap_q - GAP_ONE;
                    done_d = (gap_q == GAP_ONE);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_dummy_stim_gen.sv
// Directed bench for dummy_stim_gen: expected PRBS bits are queued at start and popped on each valid beat.
module tb_dummy_stim_gen;

    localparam int W   = 7;
    localparam int BLW = 8;
    localparam int GAP = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           reseed;
    logic [BLW-1:0] burst_len;
    logic           hold;
    logic           out;
    logic           valid;
    logic           busy;
    logic           done;
    logic [BLW-1:0] bit_count;

    dummy_stim_gen #(
        .LFSR_WIDTH (W),
        .LFSR_TAPS  (7'h60),
        .SEED       (7'h7F),
        .BURST_LEN_W(BLW),
        .IDLE_GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .reseed   (reseed),
        .burst_len(burst_len),
        .hold     (hold),
        .out      (out),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    bit           prbs [0:126];
    int           seq_idx = 0;
    bit           q_exp [$];
    int           valid_cnt, done_cnt, extra_cnt;
    int           first_valid, last_valid, done_at, t0;
    logic [127:0] cap;
    logic [127:0] cap_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observations are taken 1ns after each rising edge; cyc numbers the edges.
    task automatic step();
        bit e;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
            cap = {cap[126:0], out};
            if (q_exp.size() == 0) begin
                extra_cnt++;
            end else begin
                e = q_exp.pop_front();
                check("out_bit", 32'(out), 32'(e));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
        if (busy !== 1'b1) begin
            check("idle_valid", 32'(valid), 0);
            check("idle_out", 32'(out), 0);
        end
    endtask

    task automatic clear_stats();
        valid_cnt   = 0;
        done_cnt    = 0;
        extra_cnt   = 0;
        first_valid = -1;
        last_valid  = -1;
        done_at     = -1;
        cap         = '0;
    endtask

    task automatic start_burst(input int len, input bit rs);
        if (rs) seq_idx = 0;
        for (int i = 0; i < len; i++) q_exp.push_back(prbs[(seq_idx + i) % 127]);
        seq_idx   = (seq_idx + len) % 127;
        start     = 1'b1;
        reseed    = rs;
        burst_len = BLW'(len);
        step();
        t0        = cyc;
        start     = 1'b0;
        reseed    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("busy_timeout", 32'(busy), 0);
    endtask

    initial begin
        // Independent recurrence for x^7+x^6+1 output stream: o[n] = o[n-7] ^ o[n-6].
        for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
        for (int i = 7; i < 127; i++) prbs[i] = prbs[i-7] ^ prbs[i-6];

        rst_n = 1'b0; start = 1'b0; reseed = 1'b0; hold = 1'b0; burst_len = '0;
        clear_stats();
        #12;
        check("rst_out", 32'(out), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bit_count", 32'(bit_count), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // Burst of 8 from the seed; spec cycle T+k is observed after edge T+k-1.
        clear_stats();
        start_burst(8, 1'b1);
        check("t1_busy_rise", 32'(busy), 1);
        check("t1_no_valid_yet", 32'(valid), 0);
        wait_idle(40);
        check("t1_first_valid", first_valid - t0, 1);
        check("t1_last_valid", last_valid - t0, 8);
        check("t1_valid_cnt", valid_cnt, 8);
        check("t1_bits", 32'(cap[7:0]), 254);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_at", done_at - t0, 12);
        check("t1_busy_low_at", cyc - t0, 13);
        check("t1_bit_count", 32'(bit_count), 8);
        check("t1_queue", q_exp.size(), 0);
        check("t1_extra", extra_cnt, 0);

        // hold in IDLE does nothing.
        hold = 1'b1;
        step();
        check("hold_idle_busy", 32'(busy), 0);
        hold = 1'b0;

        // Burst of 20 with a 3-cycle hold after the 4th bit.
        clear_stats();
        start_burst(20, 1'b1);
        repeat (4) step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_valid", 32'(valid), 0);
            check("t2_hold_out", 32'(out), 32'(prbs[3]));
            check("t2_hold_cnt", 32'(bit_count), 4);
        end
        hold = 1'b0;
        wait_idle(60);
        check("t2_valid_cnt", valid_cnt, 20);
        check("t2_hole_cycles", (last_valid - first_valid + 1) - valid_cnt, 3);
        check("t2_bit_count", 32'(bit_count), 20);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_queue", q_exp.size(), 0);
        check("t2_extra", extra_cnt, 0);

        // Two full periods, reseeded then continued; then the LFSR must be back at the seed.
        clear_stats();
        start_burst(127, 1'b1);
        wait_idle(300);
        check("t3a_valid_cnt", valid_cnt, 127);
        check("t3a_bit_count", 32'(bit_count), 127);
        cap_a = cap;
        clear_stats();
        start_burst(127, 1'b0);
        wait_idle(300);
        check("t3b_valid_cnt", valid_cnt, 127);
        check("t3_identical", 32'(cap[126:0] === cap_a[126:0]), 1);
        clear_stats();
        start_burst(7, 1'b0);
        wait_idle(40);
        check("t3_wrap_to_seed", 32'(cap[6:0]), 127);
        check("t3_queue", q_exp.size(), 0);
        check("t3_extra", extra_cnt, 0);

        // start held high through RUN, GAP and the done cycle must be ignored.
        clear_stats();
        start_burst(10, 1'b0);
        start = 1'b1; reseed = 1'b1; burst_len = 8'd3;
        begin
            int n = 0;
            while (done !== 1'b1 && n < 60) begin
                step();
                n++;
            end
        end
        check("t4_done_seen", 32'(done), 1);
        step();
        start = 1'b0; reseed = 1'b0;
        repeat (8) step();
        check("t4_busy", 32'(busy), 0);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_valid_cnt", valid_cnt, 10);
        check("t4_bit_count", 32'(bit_count), 10);
        check("t4_queue", q_exp.size(), 0);
        check("t4_extra", extra_cnt, 0);

        // Zero-length burst.
        clear_stats();
        start_burst(0, 1'b0);
        check("t5_busy_rise", 32'(busy), 1);
        wait_idle(40);
        check("t5_valid_cnt", valid_cnt, 0);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_done_at", done_at - t0, GAP);
        check("t5_busy_low_at", cyc - t0, GAP + 1);
        check("t5_bit_count", 32'(bit_count), 0);

        // Asynchronous reset at bit 10 of 50.
        clear_stats();
        start_burst(50, 1'b1);
        repeat (10) step();
        check("t6_mid_valid", 32'(valid), 1);
        check("t6_mid_count", 32'(bit_count), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 32'(out), 0);
        check("t6_rst_valid", 32'(valid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_bit_count", 32'(bit_count), 0);
        q_exp.delete();
        seq_idx = 0;
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("t6_no_done", done_cnt, 0);
        clear_stats();
        start_burst(12, 1'b0);
        wait_idle(60);
        check("t6_restart_seed", 32'(cap[11:5]), 127);
        check("t6_valid_cnt", valid_cnt, 12);
        check("t6_queue", q_exp.size(), 0);
        check("t6_extra", extra_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dummy_stim_gen.md
Name: dummy_stim_gen

Overview:
- PRBS stimulus transmitter that drives the serial `in` input of the dummy XOR chain blocks in the timing-closure example designs.
- Emits bursts of registered pseudo-random bits with a valid strobe.
- Uses a start/done handshake and supports a hold/pause input.
- Keeps the example designs self-stimulating, so synthesis cannot prune the downstream chains.

Parameters:
- LFSR_WIDTH, 7: Fibonacci LFSR width.
- LFSR_TAPS, 7'h60: feedback tap mask. Default is PRBS7, x^7+x^6+1 (bits 6 and 5).
- SEED, 7'h7F: load value on reset and on start with reseed=1.
- BURST_LEN_W, 8: width of the burst length and bit counters.
- IDLE_GAP, 4: quiet cycles after a burst before done. Must be at least 1.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: burst request; sampled only in IDLE.
- reseed, input, 1: sampled with start. 1 = load SEED; 0 = continue from the current LFSR state.
- burst_len, input, BURST_LEN_W: number of bits to emit; sampled with start.
- hold, input, 1: pause emission while in RUN.
- out, output, 1: registered serial stimulus bit.
- valid, output, 1: out carries a new PRBS bit this cycle.
- busy, output, 1: high in RUN and GAP.
- done, output, 1: one-cycle end-of-burst pulse.
- bit_count, output, BURST_LEN_W: bits emitted in the current burst; holds its value after the burst.

Behaviour:
- Reset (async, rst_n=0):
  - out=0, valid=0, busy=0, done=0, bit_count=0.
  - state=IDLE, LFSR=SEED.
  - Reset mid-burst aborts immediately; no done pulse is generated.
- SEED==0 lock-up guard: if the SEED parameter is 0, the value 1 is loaded instead. The LFSR is never all-zero.
- States: IDLE, RUN, GAP.
- IDLE:
  - On start=1, latch burst_len into remaining and clear bit_count.
  - If reseed=1, LFSR<=SEED (lock-up guarded).
  - If burst_len!=0, next state is RUN. If burst_len==0, next state is GAP with no bits emitted.
  - busy rises the cycle after start is sampled.
- RUN, hold=0, each edge:
  - out<=LFSR[W-1], valid<=1.
  - LFSR<={LFSR[W-2:0], ^(LFSR & LFSR_TAPS)}.
  - remaining-1, bit_count+1.
  - On the edge emitting the last bit (remaining==1), next state is GAP with gap counter=IDLE_GAP.
- RUN, hold=1:
  - valid<=0; out holds its last value.
  - LFSR, remaining and bit_count are frozen.
  - hold may toggle on any cycle; resuming continues the same sequence with no bit lost or repeated.
- Latency:
  - start sampled at edge T puts the first valid bit on out during cycle T+2.
  - With hold=0, valid is high for exactly burst_len consecutive cycles.
- GAP:
  - valid=0, out=0, busy=1.
  - The gap counter decrements each edge.
  - With last valid cycle L, done=1 during cycle L+IDLE_GAP only; busy=0 from cycle L+IDLE_GAP+1, when state is back in IDLE.
  - For burst_len==0, done is high IDLE_GAP cycles after the cycle in which busy rises.
- start while busy: ignored, not queued. A start in the same cycle as done is also ignored.
- hold in IDLE/GAP: no effect.
- reseed=0 across bursts: the sequence continues seamlessly, so burst B's first bit follows burst A's last bit in the PRBS.
- Counter widths:
  - burst_len maximum is 2^BURST_LEN_W-1.
  - bit_count never wraps within a burst.
- Sequence check: PRBS7 from 7'h7F emits 1,1,1,1,1,1,1,0,0,0,0,0,0,1,0,…; period is 127.

Test Plan:
- Reset, then start=1, reseed=1, burst_len=8 at edge T:
  - valid high cycles T+2..T+9; out=1111_1110.
  - done high only in cycle T+13; busy low from T+14; bit_count=8.
- burst_len=20 with hold=1 for cycles 5-7 of emission:
  - valid gaps exactly 3 cycles.
  - Emitted 20 bits equal the uninterrupted PRBS7 bits 1-20; bit_count=20.
- burst_len=127 with reseed=1, then a second burst of 127 with reseed=0:
  - Each burst equals one full PRBS7 period.
  - Both bursts are bit-identical; LFSR ends at 7'h7F.
- start pulses while busy and in the done cycle: ignored. Exactly one done per accepted start, and burst length is unchanged.
- burst_len=0: valid never asserts; done pulses IDLE_GAP cycles after busy rises; bit_count=0.
- rst_n asserted asynchronously mid-RUN, at bit 10 of 50:
  - All outputs drop to 0 immediately; no done pulse.
  - After release, a new start with reseed=0 restarts from SEED, with the first bits 1111111.
